fpu_batch_sequencer: RTL and testbench

FPU_BATCH_SEQUENCER -- requirements
Module: fpu_batch_sequencer

---
 rtl/fpu_batch_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fpu_batch_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_batch_sequencer.sv
// Batch sequencer: fetches num_ops operand pairs, drives them through an external FPU/ALU and streams results.
// Defining SEQ_TIMEOUT_EN adds a WAIT_ALU watchdog of TIMEOUT_CYC cycles that reports timeout_err.
module fpu_batch_sequencer #(
  parameter int unsigned OPERAND_LAT = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [3:0]  num_ops,
  input  logic [1:0]  op_mode,
  output logic        load_req,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [3:0]  op_index,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_OPND = 3'd2,
    ISSUE     = 3'd3,
    WAIT_ALU  = 3'd4,
    WRITE     = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(OPERAND_LAT);

  state_t     state_r;
  state_t     state_s;
  logic       run_d_r;
  logic       run_rise_s;
  logic [3:0] last_idx_r;
  logic [3:0] count_r;
  logic [3:0] lat_cnt_r;
  logic [1:0] op_mode_r;
  logic       opnd_ready_s;
  logic       timeout_hit_s;

  // run_d_r resets high so a run level already present at reset release is not an edge
  assign run_rise_s   = run & ~run_d_r;
  assign opnd_ready_s = (lat_cnt_r == LAT_LAST);

`ifdef SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 32'd1);
  logic [15:0] wdog_r;

  assign timeout_hit_s = (state_r == WAIT_ALU) && !alu_done && (wdog_r == WD_LAST);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (run_rise_s) state_s = REQ;
        else            state_s = IDLE;
      end
      REQ: state_s = WAIT_OPND;
      WAIT_OPND: begin
        if (opnd_ready_s) state_s = ISSUE;
        else              state_s = WAIT_OPND;
      end
      ISSUE: state_s = WAIT_ALU;
      WAIT_ALU: begin
        if (alu_done)           state_s = WRITE;
        else if (timeout_hit_s) state_s = DONE;
        else                    state_s = WAIT_ALU;
      end
      WRITE: begin
        if (count_r == last_idx_r) state_s = DONE;
        else                       state_s = REQ;
      end
      DONE: begin
        if (!run) state_s = IDLE;
        else      state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered strobes/status decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      run_d_r      <= 1'b1;
      load_req     <= 1'b0;
      alu_start    <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r      <= state_s;
      run_d_r      <= run;
      load_req     <= (state_s == REQ);
      alu_start    <= (state_s == ISSUE);
      result_valid <= (state_s == WRITE);
      busy         <= (state_s != IDLE) && (state_s != DONE);
      done         <= (state_s == DONE);
    end
  end

  // Batch configuration, operand capture, result capture and position counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx_r <= 4'd0;
      op_mode_r  <= 2'd0;
      count_r    <= 4'd0;
      lat_cnt_r  <= 4'd0;
      alu_A      <= 32'd0;
      alu_B      <= 32'd0;
      alu_op     <= 2'd0;
      result     <= 32'd0;
      op_index   <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (run_rise_s) begin
            // num_ops of 0 wraps to a last index of 15, i.e. a 16-op batch
            last_idx_r <= num_ops - 4'd1;
            op_mode_r  <= op_mode;
            count_r    <= 4'd0;
          end
        end
        REQ: lat_cnt_r <= 4'd1;
        WAIT_OPND: begin
          if (opnd_ready_s) begin
            alu_A  <= A_in;
            alu_B  <= B_in;
            alu_op <= op_mode_r;
          end else begin
            lat_cnt_r <= lat_cnt_r + 4'd1;
          end
        end
        WAIT_ALU: begin
          if (alu_done) begin
            result   <= alu_result;
            op_index <= count_r;
          end
        end
        WRITE: begin
          if (count_r != last_idx_r) count_r <= count_r + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Watchdog counts cycles spent in WAIT_ALU; the error flag is cleared only by a new batch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r      <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      if ((state_r == IDLE) && run_rise_s) timeout_err <= 1'b0;
      else if (timeout_hit_s)              timeout_err <= 1'b1;
      if (state_r == WAIT_ALU) wdog_r <= wdog_r + 16'd1;
      else                     wdog_r <= 16'd0;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_batch_sequencer.sv
// Self-checking bench for fpu_batch_sequencer: table-driven batches plus directed reset/ignore/timeout sequences.
module tb_fpu_batch_sequencer;
  localparam int LAT = 2;
  localparam int TMO = 64;
  localparam int NV  = 6;

  typedef struct { logic [31:0] a; logic [31:0] b; } opnd_t;
  typedef struct { logic [31:0] res; logic [3:0] idx; } exp_t;
  typedef struct { logic [3:0] n; logic [1:0] mode; int delay; bit drop_run; int ops; } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run = 1'b0;
  logic [3:0]  num_ops = 4'd0;
  logic [1:0]  op_mode = 2'd0;
  logic        load_req;
  logic [31:0] A_in = 32'd0;
  logic [31:0] B_in = 32'd0;
  logic [31:0] alu_A, alu_B;
  logic [1:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] result;
  logic        result_valid;
  logic [3:0]  op_index;
  logic        busy, done, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, alu_cnt = 0, alu_delay = 1;
  int lr_count = 0, res_count = 0, start_count = 0, lr_cyc = 0, start_cyc = 0;
  int src_n = 0, src_k = 0;
  logic [1:0]  cur_mode = 2'd0;
  logic [15:0] lr_hist = 16'd0;
  logic [31:0] alu_res_pend = 32'd0;
  logic [31:0] last_exp = 32'd0;
  bit          inj_done = 1'b0;
  opnd_t opnd_q[$];
  exp_t  exp_q[$];
  vec_t  vecs[NV];

  fpu_batch_sequencer #(.OPERAND_LAT(LAT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .num_ops(num_ops), .op_mode(op_mode),
    .load_req(load_req), .A_in(A_in), .B_in(B_in), .alu_A(alu_A), .alu_B(alu_B),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .result(result), .result_valid(result_valid), .op_index(op_index),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mock_alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    case (m)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] gen_a(input int n);
    return (n == 0) ? 32'h40224dd3 : 32'h4000_0000 + 32'(n) * 32'h0001_0203;
  endfunction

  function automatic logic [31:0] gen_b(input int n);
    return (n == 0) ? 32'h3fc3d70a : 32'h3f80_0000 ^ (32'(n) * 32'h0000_0f11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operand source, mock ALU and result scoreboard, all driven/sampled on the falling edge
  always @(negedge clk) begin
    opnd_t o;
    exp_t  e;
    logic [31:0] va, vb;
    cyc = cyc + 1;
    alu_done = 1'b0;
    if (inj_done) begin
      alu_done = 1'b1;
      alu_result = 32'hDEAD_BEEF;
      inj_done = 1'b0;
    end
    if (alu_cnt > 0) begin
      alu_cnt = alu_cnt - 1;
      if (alu_cnt == 0) begin
        alu_done = 1'b1;
        alu_result = alu_res_pend;
      end
    end
    if (alu_start) begin
      start_count++;
      start_cyc = cyc;
      chk("opnd_pending", 32'(opnd_q.size()), 32'd1);
      if (opnd_q.size() > 0) begin
        o = opnd_q.pop_front();
        chk("alu_A", alu_A, o.a);
        chk("alu_B", alu_B, o.b);
        chk("alu_op", 32'(alu_op), 32'(cur_mode));
      end
      alu_res_pend = mock_alu(alu_A, alu_B, alu_op);
      alu_cnt = alu_delay;
    end
    lr_hist = {lr_hist[14:0], load_req};
    if (load_req) begin
      lr_count++;
      lr_cyc = cyc;
    end
    if (lr_hist[LAT]) begin
      va = gen_a(src_n);
      vb = gen_b(src_n);
      opnd_q.push_back('{a: va, b: vb});
      exp_q.push_back('{res: mock_alu(va, vb, cur_mode), idx: 4'(src_k)});
      A_in = va;
      B_in = vb;
      src_n++;
      src_k++;
    end else begin
      A_in = 32'hBAD0_0000 ^ 32'(cyc);
      B_in = ~A_in;
    end
    if (result_valid) begin
      res_count++;
      chk("exp_pending", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("op_index", 32'(op_index), 32'(e.idx));
        last_exp = e.res;
      end
      if (alu_delay == 1) chk("min_latency", 32'(cyc - lr_cyc + 1), 32'(LAT + 4));
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_load_req"}, 32'(load_req), 32'd0);
    chk({tag, "_alu_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_alu_A"}, alu_A, 32'd0);
    chk({tag, "_alu_B"}, alu_B, 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_op_index"}, 32'(op_index), 32'd0);
  endtask

  task automatic start_batch(input logic [3:0] n, input logic [1:0] m, input int d);
    cur_mode = m;
    alu_delay = d;
    src_k = 0;
    lr_count = 0;
    res_count = 0;
    start_count = 0;
    num_ops = n;
    op_mode = m;
    run = 1'b1;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    start_batch(v.n, v.mode, v.delay);
    repeat (3) @(negedge clk);
    #1;
    num_ops = ~v.n;
    op_mode = ~v.mode;
    if (v.drop_run) run = 1'b0;
    wait_done(seen);
    chk("done_seen", 32'(seen), 32'd1);
    chk("load_req_count", 32'(lr_count), 32'(v.ops));
    chk("result_count", 32'(res_count), 32'(v.ops));
    chk("busy_in_done", 32'(busy), 32'd0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("done_cleared", 32'(done), 32'd0);
    chk("no_extra_load_req", 32'(lr_count), 32'(v.ops));
  endtask

  initial begin
    bit seen;
    logic [31:0] saved;
    vecs[0] = '{n: 4'd4,  mode: 2'b10, delay: 3, drop_run: 1'b0, ops: 4};
    vecs[1] = '{n: 4'd0,  mode: 2'b00, delay: 1, drop_run: 1'b0, ops: 16};
    vecs[2] = '{n: 4'd1,  mode: 2'b01, delay: 1, drop_run: 1'b0, ops: 1};
    vecs[3] = '{n: 4'd3,  mode: 2'b11, delay: 5, drop_run: 1'b1, ops: 3};
    vecs[4] = '{n: 4'd15, mode: 2'b10, delay: 2, drop_run: 1'b0, ops: 15};
    vecs[5] = '{n: 4'd2,  mode: 2'b00, delay: 1, drop_run: 1'b0, ops: 2};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // alu_done while idle must not touch result
    saved = last_exp;
    res_count = 0;
    inj_done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_done_result", result, saved);
    chk("idle_done_no_valid", 32'(res_count), 32'd0);

    // alu_done during WAIT_OPND must be ignored
    start_batch(4'd1, 2'b01, 2);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (load_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("opnd_lr_seen", 32'(seen), 32'd1);
    inj_done = 1'b1;
    wait_done(seen);
    chk("opnd_inj_done_seen", 32'(seen), 32'd1);
    chk("opnd_inj_count", 32'(res_count), 32'd1);
    chk("opnd_inj_result", result, last_exp);
    run = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // reset asserted in WAIT_ALU of op 2 of 4, run held high through release
    start_batch(4'd4, 2'b11, 20);
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); #1;
      if (start_count == 3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_op2_start_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    lr_hist = 16'd0;
    opnd_q.delete();
    exp_q.delete();
    res_count = 0;
    lr_count = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    chk("rst_no_restart_lr", 32'(lr_count), 32'd0);
    chk("rst_no_result", 32'(res_count), 32'd0);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    chk("rst_result_kept_zero", result, 32'd0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // ALU never answers
    start_batch(4'd2, 2'b01, 0);
`ifdef SEQ_TIMEOUT_EN
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (start_count == 1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tmo_start_seen", 32'(seen), 32'd1);
    wait_done(seen);
    chk("tmo_done_seen", 32'(seen), 32'd1);
    chk("tmo_done_delay", 32'(cyc - start_cyc), 32'(TMO + 1));
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_no_result", 32'(res_count), 32'd0);
    exp_q.delete();
    run = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
    start_batch(4'd1, 2'b00, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("tmo_err_cleared", 32'(timeout_err), 32'd0);
    wait_done(seen);
    chk("tmo_next_done", 32'(seen), 32'd1);
    chk("tmo_next_count", 32'(res_count), 32'd1);
    run = 1'b0;
    repeat (2) @(negedge clk);
    #1;
`else
    repeat (150) @(negedge clk);
    #1;
    chk("hang_busy", 32'(busy), 32'd1);
    chk("hang_done", 32'(done), 32'd0);
    chk("hang_timeout_err", 32'(timeout_err), 32'd0);
    chk("hang_no_result", 32'(res_count), 32'd0);
    rst_n = 1'b0;
    run = 1'b0;
    exp_q.delete();
    opnd_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("hang_recover_busy", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, want completion before 200000", $time);
    $fatal(1);
  end

endmodule
